// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: default geometry, FSM states,
// requester ids and the read-tracking pipeline entry.
package ram_arbiter_pkg;

    localparam int unsigned AW_DEF     = 7;
    localparam int unsigned DW_DEF     = 16;
    localparam int unsigned RD_LAT_DEF = 2;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t port;
    } rd_track_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester's request/response bundle. The client drives the request side;
// the arbiter answers with ready and the read-data return.
interface ram_arbiter_if #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 16
) ();

    logic          valid;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rvalid, rdata
    );

endinterface

// File: rtl/ram_arbiter_rampipe.sv
// rampipe: single-port RAM macro (active-low WEN/OEN, read data latched on the
// clock edge, Q driven only while OEN=0) followed by an output register.
// The undriven Q bus reads as zero.
module rampipe #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 16
) (
    input  logic          CLK,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D,
    input  logic          WEN,
    input  logic          OEN,
    output logic [DW-1:0] QP
);

    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] q_lat;
    logic [DW-1:0] q_bus;

    // Macro core: write when WEN=0, otherwise latch the addressed word.
    always_ff @(posedge CLK) begin
        if (!WEN) begin
            mem[A] <= D;
        end else begin
            q_lat <= mem[A];
        end
    end

    assign q_bus = OEN ? '0 : q_lat;

    // Output register samples the macro Q bus one edge after the read edge.
    always_ff @(posedge CLK) begin
        QP <= q_bus;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a pipelined RAM. After reset an
// optional sweep writes INIT_VAL to every address; then one access per cycle is
// granted and read data returns to the issuing port RD_LAT cycles later.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned RD_LAT   = RD_LAT_DEF,
    parameter bit          INIT_EN  = 1'b1,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          CLK,
    input  logic          RST,
    ram_arbiter_if.slave  p0,
    ram_arbiter_if.slave  p1,
    output logic          init_done
);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] cnt;
    port_id_t      last_gnt;
    logic          gnt0;
    logic          gnt1;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_d;
    logic          ram_wen;
    logic          ram_oen;
    logic [DW-1:0] ram_q;
    rd_track_t     pipe [RD_LAT];
    logic          rv0;
    logic          rv1;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    // State register; reset restarts the sweep (or goes straight to RUN).
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= INIT_EN ? ST_INIT : ST_RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, round-robin grant and RAM control.
    always_comb begin
        state_nx = state;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        ram_a    = cnt;
        ram_d    = INIT_VAL;
        ram_wen  = 1'b1;
        case (state)
            ST_INIT: begin
                ram_wen = 1'b0;
                if (cnt == '1) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (p0.valid && (!p1.valid || last_gnt == PORT1)) begin
                    gnt0 = 1'b1;
                end else if (p1.valid) begin
                    gnt1 = 1'b1;
                end
                if (gnt0) begin
                    ram_a   = p0.addr;
                    ram_d   = p0.wdata;
                    ram_wen = ~p0.we;
                end else if (gnt1) begin
                    ram_a   = p1.addr;
                    ram_d   = p1.wdata;
                    ram_wen = ~p1.we;
                end
            end
            default: state_nx = ST_INIT;
        endcase
    end

    // Sweep counter, init_done flag and last-granted pointer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt       <= '0;
            init_done <= ~INIT_EN;
            last_gnt  <= PORT1;
        end else begin
            if (state == ST_INIT) begin
                cnt <= cnt + 1'b1;
            end
            if (state_nx == ST_RUN) begin
                init_done <= 1'b1;
            end
            if (gnt0) begin
                last_gnt <= PORT0;
            end else if (gnt1) begin
                last_gnt <= PORT1;
            end
        end
    end

    // Read tracker: {valid, port} shifts alongside the RAM read pipeline.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: (gnt0 && !p0.we) || (gnt1 && !p1.we),
                         port:  gnt1 ? PORT1 : PORT0};
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Q must be driven in the cycle after a read grant, when rampipe samples it.
    assign ram_oen = ~pipe[0].valid;

    rampipe #(
        .AW (AW),
        .DW (DW)
    ) u_rampipe (
        .CLK (CLK),
        .A   (ram_a),
        .D   (ram_d),
        .WEN (ram_wen),
        .OEN (ram_oen),
        .QP  (ram_q)
    );

    assign rv0 = pipe[RD_LAT-1].valid && (pipe[RD_LAT-1].port == PORT0);
    assign rv1 = pipe[RD_LAT-1].valid && (pipe[RD_LAT-1].port == PORT1);

    // Per-port hold registers keep rdata steady between responses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (rv0) rdata0_q <= ram_q;
            if (rv1) rdata1_q <= ram_q;
        end
    end

    assign p0.ready  = gnt0;
    assign p1.ready  = gnt1;
    assign p0.rvalid = rv0;
    assign p1.rvalid = rv1;
    assign p0.rdata  = rv0 ? ram_q : rdata0_q;
    assign p1.rdata  = rv1 ? ram_q : rdata1_q;

endmodule
